// File: rtl/ths8200_i2c_pkg.sv
// Shared types and constants for the THS8200 I2C target model.
package ths8200_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_e;

    localparam logic [6:0] THS8200_DEV_ADDR = 7'h20;
    // Holds 0..8: eight data bits plus the "byte finished" count in RDATA
    localparam int         I2C_BIT_CNT_W    = 4;
    localparam int         DEFAULT_FILT_LEN = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer, glitch filter and edge flags for one open-drain I2C line.
module i2c_line_filter
    import ths8200_i2c_pkg::*;
#(
    parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic line_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic       level_prev;
    logic [3:0] run_cnt;

    // Two-flop synchronizer; idles high like a released bus line
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= line_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b1;
            level_prev <= 1'b1;
            run_cnt    <= '0;
        end else begin
            level_prev <= level;
            if (sync_p1 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == 4'(FILT_LEN - 1)) begin
                level   <= sync_p1;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

    assign rise = level & ~level_prev;
    assign fall = ~level & level_prev;

endmodule

// File: rtl/ths8200_i2c_responder.sv
// I2C target model of the THS8200 control port: 256x8 register file with
// sub-address auto-increment, write-event stream and a registered peek port.
module ths8200_i2c_responder
    import ths8200_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = THS8200_DEV_ADDR,
    parameter int         FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] wr_count,
    input  logic [7:0] peek_addr,
    output logic [7:0] peek_data
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det, byte_done;

    i2c_state_e               state_q, state_d;
    logic [I2C_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]               sr_q, sr_d;
    logic [7:0]               byte_in, mem_rd;
    logic [7:0]               ptr_q, ptr_d;
    logic [7:0]               rbyte_q, rbyte_d;
    logic                     oe_d, busy_d;
    logic                     rd_load_q, rd_load_d;
    logic                     wr_en;

    logic [7:0] regfile [256];

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk      (clk),
        .rst      (rst),
        .line_raw (scl_in),
        .level    (scl_lvl),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk      (clk),
        .rst      (rst),
        .line_raw (sda_in),
        .level    (sda_lvl),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    // SCL high now and last cycle (any SCL edge excludes this), SDA moving
    assign start_det = sda_fall & scl_lvl & ~scl_rise;
    assign stop_det  = sda_rise & scl_lvl & ~scl_rise;
    assign byte_in   = {sr_q, sda_lvl};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
    assign mem_rd    = regfile[ptr_q];

    // Next-state and output decode; START/STOP override any bit activity
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rbyte_d   = rbyte_q;
        oe_d      = sda_oe;
        busy_d    = busy;
        rd_load_d = rd_load_q;
        wr_en     = 1'b0;

        if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
            rd_load_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            rd_load_d = 1'b0;
        end else begin
            if (scl_rise && (state_q == DEV || state_q == SUB || state_q == WDATA)) begin
                sr_d      = byte_in[6:0];
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            unique case (state_q)
                DEV: if (byte_done) begin
                    bit_cnt_d = '0;
                    state_d   = (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE;
                end
                SUB: if (byte_done) begin
                    bit_cnt_d = '0;
                    ptr_d     = byte_in;
                    state_d   = SUB_ACK;
                end
                WDATA: if (byte_done) begin
                    bit_cnt_d = '0;
                    wr_en     = 1'b1;
                    ptr_d     = ptr_q + 8'd1;
                    state_d   = WACK;
                end
                // ACK spans 8th fall to 9th fall; sda_oe itself tells the two falls apart
                DEV_ACK, SUB_ACK, WACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d = 1'b0;
                        if (state_q != DEV_ACK) begin
                            state_d = WDATA;
                        end else if (sr_q[0]) begin
                            // Read: first data bit goes out on this same fall
                            state_d   = RDATA;
                            bit_cnt_d = '0;
                            rbyte_d   = mem_rd;
                            oe_d      = ~mem_rd[7];
                        end else begin
                            state_d = SUB;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise && !rd_load_q) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (rd_load_q) begin
                            rd_load_d = 1'b0;
                            bit_cnt_d = '0;
                            rbyte_d   = mem_rd;
                            oe_d      = ~mem_rd[7];
                        end else if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            oe_d      = 1'b0;
                            state_d   = RACK;
                        end else begin
                            oe_d = ~rbyte_q[~bit_cnt_q[2:0]];
                        end
                    end
                end
                RACK: if (scl_rise) begin
                    ptr_d = ptr_q + 8'd1;
                    if (!sda_lvl) begin
                        state_d   = RDATA;
                        rd_load_d = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state and write-event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            ptr_q     <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rd_load_q <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_count  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            sda_oe    <= oe_d;
            busy      <= busy_d;
            rd_load_q <= rd_load_d;
            wr_valid  <= wr_en;
            if (wr_en) begin
                wr_addr  <= ptr_q;
                wr_data  <= byte_in;
                wr_count <= wr_count + 8'd1;
            end
        end
    end

    // Shift and read-byte holding registers carry data only
    always_ff @(posedge clk) begin
        sr_q    <= sr_d;
        rbyte_q <= rbyte_d;
    end

    // Register-file write port; contents survive rst
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            regfile[ptr_q] <= byte_in;
        end
    end

    // Registered peek port
    always_ff @(posedge clk) begin
        if (rst) begin
            peek_data <= '0;
        end else begin
            peek_data <= regfile[peek_addr];
        end
    end

endmodule

// File: tb/tb_ths8200_i2c_responder.sv
// Directed bench for ths8200_i2c_responder: a bit-banged I2C master on an
// open-drain bus, a write-event logger and hand-computed expectations.
module tb_ths8200_i2c_responder;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_in;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] wr_count;
    logic [7:0] peek_addr;
    logic [7:0] peek_data;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         oe_cnt = 0;
    logic [7:0] ev_addr[$];
    logic [7:0] ev_data[$];

    always #5 clk = ~clk;

    assign sda_in = sda_m & ~sda_oe;

    ths8200_i2c_responder dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_count  (wr_count),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    // Log every write event and every cycle the target pulls SDA
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            ev_addr.push_back(wr_addr);
            ev_data.push_back(wr_data);
        end
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    task automatic i2c_bit(input logic b, input logic glitch, output logic r);
        sda_m = b; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        if (glitch) begin
            scl_m = 1'b0; wait_clks(2);
            scl_m = 1'b1; wait_clks(Q);
        end
        r = sda_in; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_wr_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], (i == glitch_bit), r);
        i2c_bit(1'b1, 1'b0, ack);
    endtask

    task automatic i2c_rd_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        i2c_bit(mack, 1'b0, r);
    endtask

    task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
        peek_addr = a;
        wait_clks(1);
        check_val(tag, peek_data, exp);
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] rd;
        int         oe_mark;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; peek_addr = 8'h00;
        wait_clks(4);
        check_val("rst_sda_oe", 8'(sda_oe), 8'h00);
        check_val("rst_busy", 8'(busy), 8'h00);
        check_val("rst_wr_valid", 8'(wr_valid), 8'h00);
        check_val("rst_wr_addr", wr_addr, 8'h00);
        check_val("rst_wr_data", wr_data, 8'h00);
        check_val("rst_wr_count", wr_count, 8'h00);
        check_val("rst_peek", peek_data, 8'h00);
        rst = 1'b0;
        wait_clks(2 * Q);

        // Single write 0x03 <= 0x01
        i2c_start();
        check_val("w1_busy", 8'(busy), 8'h01);
        i2c_wr_byte(8'h40, -1, ack); check_val("w1_ack_dev", 8'(ack), 8'h00);
        i2c_wr_byte(8'h03, -1, ack); check_val("w1_ack_sub", 8'(ack), 8'h00);
        i2c_wr_byte(8'h01, -1, ack); check_val("w1_ack_dat", 8'(ack), 8'h00);
        i2c_stop();
        wait_clks(Q);
        check_val("w1_busy_off", 8'(busy), 8'h00);
        check_val("w1_nev", 8'(ev_addr.size()), 8'd1);
        check_val("w1_addr", ev_addr[0], 8'h03);
        check_val("w1_data", ev_data[0], 8'h01);
        check_val("w1_count", wr_count, 8'd1);
        peek(8'h03, 8'h01, "w1_peek");

        // Burst across the 0xFF -> 0x00 pointer wrap
        i2c_start();
        i2c_wr_byte(8'h40, -1, ack);
        i2c_wr_byte(8'hFE, -1, ack);
        i2c_wr_byte(8'hAA, -1, ack); check_val("b_ack0", 8'(ack), 8'h00);
        i2c_wr_byte(8'hBB, -1, ack);
        i2c_wr_byte(8'hCC, -1, ack); check_val("b_ack2", 8'(ack), 8'h00);
        i2c_stop();
        wait_clks(Q);
        check_val("b_nev", 8'(ev_addr.size()), 8'd4);
        check_val("b_addr0", ev_addr[1], 8'hFE);
        check_val("b_data0", ev_data[1], 8'hAA);
        check_val("b_addr1", ev_addr[2], 8'hFF);
        check_val("b_data1", ev_data[2], 8'hBB);
        check_val("b_addr2", ev_addr[3], 8'h00);
        check_val("b_data2", ev_data[3], 8'hCC);
        check_val("b_count", wr_count, 8'd4);
        peek(8'h00, 8'hCC, "b_peek00");
        peek(8'hFE, 8'hAA, "b_peekFE");

        // Wrong device address: never ACKed, never written
        oe_mark = oe_cnt;
        i2c_start();
        i2c_wr_byte(8'h42, -1, ack); check_val("na_ack_dev", 8'(ack), 8'h01);
        i2c_wr_byte(8'h10, -1, ack); check_val("na_ack_sub", 8'(ack), 8'h01);
        check_val("na_busy", 8'(busy), 8'h01);
        i2c_stop();
        wait_clks(Q);
        check_val("na_busy_off", 8'(busy), 8'h00);
        check_val("na_oe", 8'(oe_cnt - oe_mark), 8'h00);
        check_val("na_nev", 8'(ev_addr.size()), 8'd4);

        // Preload 0x38..0x3A, then combined write-pointer / repeated-start read
        i2c_start();
        i2c_wr_byte(8'h40, -1, ack);
        i2c_wr_byte(8'h38, -1, ack);
        i2c_wr_byte(8'h89, -1, ack);
        i2c_wr_byte(8'h22, -1, ack);
        i2c_wr_byte(8'h5C, -1, ack);
        i2c_stop();
        check_val("rd_pre_count", wr_count, 8'd7);
        i2c_start();
        i2c_wr_byte(8'h40, -1, ack);
        i2c_wr_byte(8'h38, -1, ack);
        i2c_start();
        i2c_wr_byte(8'h41, -1, ack); check_val("rd_ack_dev", 8'(ack), 8'h00);
        i2c_rd_byte(1'b0, rd); check_val("rd_byte0", rd, 8'h89);
        i2c_rd_byte(1'b1, rd); check_val("rd_byte1", rd, 8'h22);
        i2c_stop();
        i2c_start();
        i2c_wr_byte(8'h41, -1, ack);
        i2c_rd_byte(1'b1, rd); check_val("rd_ptr3A", rd, 8'h5C);
        i2c_stop();
        wait_clks(Q);
        check_val("rd_nev", 8'(ev_addr.size()), 8'd7);

        // Two-cycle low glitch on SCL during the sub-address byte
        i2c_start();
        i2c_wr_byte(8'h40, -1, ack);
        i2c_wr_byte(8'h51, 3, ack); check_val("g_ack_sub", 8'(ack), 8'h00);
        i2c_wr_byte(8'h77, -1, ack);
        i2c_stop();
        wait_clks(Q);
        check_val("g_nev", 8'(ev_addr.size()), 8'd8);
        check_val("g_addr", ev_addr[7], 8'h51);
        check_val("g_data", ev_data[7], 8'h77);

        // One-cycle rst after five bits of a data byte
        i2c_start();
        i2c_wr_byte(8'h40, -1, ack);
        i2c_wr_byte(8'h60, -1, ack);
        for (int i = 7; i >= 3; i--) i2c_bit(1'(8'hF0 >> i), 1'b0, r);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check_val("mr_sda_oe", 8'(sda_oe), 8'h00);
        check_val("mr_busy", 8'(busy), 8'h00);
        check_val("mr_count", wr_count, 8'h00);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        check_val("mr_nev", 8'(ev_addr.size()), 8'd8);
        check_val("mr_idle_busy", 8'(busy), 8'h00);
        i2c_start();
        i2c_wr_byte(8'h40, -1, ack);
        i2c_wr_byte(8'h61, -1, ack);
        i2c_wr_byte(8'h3C, -1, ack); check_val("mr_ack_dat", 8'(ack), 8'h00);
        i2c_stop();
        wait_clks(Q);
        check_val("mr2_nev", 8'(ev_addr.size()), 8'd9);
        check_val("mr2_addr", ev_addr[8], 8'h61);
        check_val("mr2_data", ev_data[8], 8'h3C);
        check_val("mr2_count", wr_count, 8'd1);
        peek(8'h61, 8'h3C, "mr2_peek");
        peek(8'h03, 8'h01, "mr_retained");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
